openofdm_rx_reset_ctrl: RTL and testbench
=========================================

Name: openofdm_rx_reset_ctrl

Overview:
- Arbitrates all receiver-restart requesters of the OFDM RX core into one timed, registered core reset pulse.
- Requesters: software (AXI register bit), signal watchdog, and header-decode failure.
- Sits between the AXI register block / signal watchdog and the dot11 core reset input.
- Enforces a minimum pulse width and a post-reset holdoff, and reports the cause plus event counts for register readback.

Parameters:
- PULSE_CYCLES, 16: core_reset high time for a single request (minimum 2).
- HOLDOFF_CYCLES, 64: cycles after pulse during which watchdog/header requests are ignored (minimum 1).
- CNT_WIDTH, 16: width of the event counters.

Ports:
- clock  in  1  receiver clock.
- reset  in  1  asynchronous, active-high reset.
- sw_rst_req  in  1  level; software restart request.
- wd_rst_req  in  1  single-cycle pulse from the signal watchdog.
- hdr_err_req  in  1  single-cycle pulse: header strobe with invalid header, or ht_unsupport.
- fcs_out_strobe  in  1  packet-complete strobe from the core.
- req_mask  in  3  per-source disable {hdr,wd,sw}; 1 = ignore that source.
- cnt_clear  in  1  single-cycle pulse; zeroes all counters.
- core_reset  out  1  registered reset to the dot11 core.
- busy  out  1  high in ASSERT or HOLDOFF.
- last_cause  out  2  0 none, 1 sw, 2 wd, 3 hdr.
- rst_cnt  out  CNT_WIDTH  total pulses issued.
- wd_cnt  out  CNT_WIDTH  watchdog-caused pulses.

Behaviour:
- Reset values: core_reset=0, busy=0, last_cause=0, all counters=0, state IDLE, sw_pending=0.
- States:
  - IDLE: no reset activity.
  - ASSERT: core_reset=1; timer loaded with PULSE_CYCLES-1.
  - HOLDOFF: core_reset=0; timer loaded with HOLDOFF_CYCLES-1.
- Effective requests: sw_e = sw_rst_req & ~req_mask[0]; wd_e = wd_rst_req & ~req_mask[1] & ~fcs_out_strobe (a watchdog pulse coincident with packet completion is discarded); hdr_e = hdr_err_req & ~req_mask[2].
- IDLE -> ASSERT when any effective request is present. Priority sw > wd > hdr. Lower-priority requests in the same cycle are discarded.
- Latency: request sampled in cycle n gives core_reset=1 and busy=1 in cycle n+1. last_cause and rst_cnt update in cycle n+1; wd_cnt also increments in n+1 when the cause is wd.
- ASSERT -> HOLDOFF when the timer reaches 0 and sw_e=0. While sw_e=1, ASSERT is held with the timer frozen at 0, so core_reset stays high for as long as the software request remains high.
- HOLDOFF -> IDLE when the timer reaches 0, unless sw_pending=1; in that case go to ASSERT with cause sw and clear sw_pending.
- Requests during ASSERT/HOLDOFF:
  - A rising edge of sw_e during HOLDOFF sets sw_pending.
  - wd/hdr requests in ASSERT or HOLDOFF are dropped and not queued.
- Pulse width: core_reset is high for exactly PULSE_CYCLES cycles per non-extended request.
- Counters saturate at all-ones and never wrap. When cnt_clear coincides with an increment, the clear wins and the counter reads 0.
- Asynchronous reset mid-pulse: core_reset drops immediately, with no pending state retained.
- last_cause holds its value until the next pulse; it is not cleared by cnt_clear.

Optional Feature:
- Macro: OPENOFDM_RX_RST_CTRL_DROP_CNT_EN.
- Defined: adds output drop_cnt [CNT_WIDTH]. It increments once per cycle in which any effective wd or hdr request is discarded, covering busy-state drops, same-cycle priority losses and fcs-coincident watchdog pulses. It saturates and is cleared by cnt_clear.
- Undefined: the port is absent and no drop logic is built.

Decomposition:
- Shared package openofdm_rx_rst_ctrl_pkg holds:
  - state encoding (IDLE=0, ASSERT=1, HOLDOFF=2);
  - cause codes (CAUSE_NONE/SW/WD/HDR);
  - saturating-increment helper function.
- One sub-module, rst_ctrl_timer: a loadable down-counter with load, freeze and zero-flag. Its width is sized from the larger of PULSE_CYCLES and HOLDOFF_CYCLES.

Test Plan:
- wd pulse at cycle 10, default parameters -> core_reset high cycles 11-26, busy high cycles 11-90, last_cause=2, rst_cnt=1, wd_cnt=1.
- sw_rst_req held for 40 cycles from cycle 5 -> core_reset high cycles 6-45, then 64 holdoff cycles, last_cause=1.
- sw, wd and hdr all pulsed in the same cycle -> one pulse, last_cause=1, wd_cnt=0; with the macro, drop_cnt=1.
- hdr pulse during HOLDOFF, then sw rising edge during HOLDOFF -> hdr ignored; second pulse starts the cycle after the holdoff ends, last_cause=1, rst_cnt=2.
- wd pulse coincident with fcs_out_strobe -> no pulse; rst_cnt stays 0. A wd pulse with req_mask=3'b010 also gives no pulse.
- Force CNT_WIDTH=2 and issue 5 wd pulses spaced 100 cycles apart -> rst_cnt saturates at 3. cnt_clear issued together with a 6th wd pulse -> rst_cnt=0. Async reset asserted mid-ASSERT -> core_reset=0 in the same cycle.

Source files
------------

// File: rtl/openofdm_rx_rst_ctrl_pkg.sv
// Shared definitions for the OFDM RX reset controller.
//   - rst_state_e : controller state encoding (idle / assert / holdoff)
//   - Cause*      : last_cause codes reported to the register block
//   - sat_inc     : saturating increment for event counters up to 32 bits wide
package openofdm_rx_rst_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StAssert  = 2'd1,
      StHoldoff = 2'd2
   } rst_state_e;

   localparam logic [1:0] CauseNone = 2'd0;
   localparam logic [1:0] CauseSw   = 2'd1;
   localparam logic [1:0] CauseWd   = 2'd2;
   localparam logic [1:0] CauseHdr  = 2'd3;

   // Increment val, sticking at the all-ones value of a width-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
      logic [31:0] max_val;
      max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (val >= max_val) ? max_val : (val + 32'd1);
   endfunction

endpackage

// File: rtl/openofdm_rx_reset_ctrl_timer.sv
// Loadable down-counter used to time the reset pulse and the holdoff window.
//   clock_i, reset_i : clock, asynchronous active-high reset
//   load_i           : load load_val_i (has priority over counting)
//   load_val_i       : value to load
//   freeze_i         : hold the current count
//   zero_o           : count is zero
// The count stops at zero on its own; it never wraps.
module rst_ctrl_timer #(
   parameter int unsigned Width = 8
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             freeze_i,
   output logic             zero_o
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (!freeze_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/openofdm_rx_reset_ctrl.sv
// Arbitrates software, watchdog and header-error restart requests into one timed, registered
// reset pulse for the dot11 core, followed by a holdoff window in which watchdog/header
// requests are ignored.
//   clock_i, reset_i   : receiver clock, asynchronous active-high reset
//   sw_rst_req_i       : software restart request (level; holding it extends the pulse)
//   wd_rst_req_i       : watchdog restart pulse
//   hdr_err_req_i      : header-decode failure pulse
//   fcs_out_strobe_i   : packet-complete strobe; a coincident watchdog pulse is discarded
//   req_mask_i         : per-source disable {hdr, wd, sw}
//   cnt_clear_i        : zero all event counters
//   core_reset_o       : registered reset to the core
//   busy_o             : pulse or holdoff in progress
//   last_cause_o       : cause of the most recent pulse (0 none, 1 sw, 2 wd, 3 hdr)
//   rst_cnt_o, wd_cnt_o: saturating counts of all pulses / watchdog-caused pulses
// Optional: define OPENOFDM_RX_RST_CTRL_DROP_CNT_EN to add drop_cnt_o, a saturating count of
// cycles in which an effective watchdog or header request was discarded.
module openofdm_rx_reset_ctrl
   import openofdm_rx_rst_ctrl_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES   = 16,
   parameter int unsigned HOLDOFF_CYCLES = 64,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 sw_rst_req_i,
   input  logic                 wd_rst_req_i,
   input  logic                 hdr_err_req_i,
   input  logic                 fcs_out_strobe_i,
   input  logic [2:0]           req_mask_i,
   input  logic                 cnt_clear_i,
   output logic                 core_reset_o,
   output logic                 busy_o,
   output logic [1:0]           last_cause_o,
   output logic [CNT_WIDTH-1:0] rst_cnt_o,
   output logic [CNT_WIDTH-1:0] wd_cnt_o
`ifdef OPENOFDM_RX_RST_CTRL_DROP_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] drop_cnt_o
`endif
);

   localparam int unsigned MaxCycles = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES
                                                                      : HOLDOFF_CYCLES;
   localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
   localparam logic [TimerW-1:0] PulseVal = TimerW'(PULSE_CYCLES - 1);
   localparam logic [TimerW-1:0] HoldVal  = TimerW'(HOLDOFF_CYCLES - 1);

   rst_state_e           state_q, state_d;
   logic                 sw_q;
   logic                 sw_pending_q, sw_pending_d;
   logic                 core_reset_q, busy_q;
   logic [1:0]           last_cause_q, last_cause_d;
   logic [CNT_WIDTH-1:0] rst_cnt_q, rst_cnt_d;
   logic [CNT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;

   logic              sw_e, wd_e, hdr_e, sw_rise, pend;
   logic              start;
   logic [1:0]        start_cause;
   logic              tmr_load, tmr_freeze, tmr_zero;
   logic [TimerW-1:0] tmr_val;

   assign sw_e    = sw_rst_req_i & ~req_mask_i[0];
   assign wd_e    = wd_rst_req_i & ~req_mask_i[1] & ~fcs_out_strobe_i;
   assign hdr_e   = hdr_err_req_i & ~req_mask_i[2];
   assign sw_rise = sw_e & ~sw_q;

   rst_ctrl_timer #(
      .Width (TimerW)
   ) u_timer (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .freeze_i   (tmr_freeze),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d      = state_q;
      sw_pending_d = sw_pending_q;
      tmr_load     = 1'b0;
      tmr_val      = PulseVal;
      tmr_freeze   = 1'b0;
      start        = 1'b0;
      start_cause  = CauseNone;
      pend         = sw_pending_q | sw_rise;
      unique case (state_q)
         StIdle: begin
            if (sw_e) begin
               start       = 1'b1;
               start_cause = CauseSw;
            end else if (wd_e) begin
               start       = 1'b1;
               start_cause = CauseWd;
            end else if (hdr_e) begin
               start       = 1'b1;
               start_cause = CauseHdr;
            end
         end
         StAssert: begin
            // A held software request parks the timer at zero and stretches the pulse.
            tmr_freeze = sw_e & tmr_zero;
            if (tmr_zero && !sw_e) begin
               state_d  = StHoldoff;
               tmr_load = 1'b1;
               tmr_val  = HoldVal;
            end
         end
         StHoldoff: begin
            if (tmr_zero) begin
               sw_pending_d = 1'b0;
               if (pend) begin
                  start       = 1'b1;
                  start_cause = CauseSw;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               sw_pending_d = pend;
            end
         end
         default: state_d = StIdle;
      endcase
      if (start) begin
         state_d  = StAssert;
         tmr_load = 1'b1;
         tmr_val  = PulseVal;
      end
   end

   always_comb begin
      last_cause_d = start ? start_cause : last_cause_q;
      rst_cnt_d    = rst_cnt_q;
      wd_cnt_d     = wd_cnt_q;
      if (start) begin
         rst_cnt_d = CNT_WIDTH'(sat_inc(32'(rst_cnt_q), CNT_WIDTH));
      end
      if (start && (start_cause == CauseWd)) begin
         wd_cnt_d = CNT_WIDTH'(sat_inc(32'(wd_cnt_q), CNT_WIDTH));
      end
      // Clear beats a coincident increment.
      if (cnt_clear_i) begin
         rst_cnt_d = '0;
         wd_cnt_d  = '0;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         sw_q         <= 1'b0;
         sw_pending_q <= 1'b0;
         core_reset_q <= 1'b0;
         busy_q       <= 1'b0;
         last_cause_q <= CauseNone;
         rst_cnt_q    <= '0;
         wd_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         sw_q         <= sw_e;
         sw_pending_q <= sw_pending_d;
         core_reset_q <= (state_d == StAssert);
         busy_q       <= (state_d != StIdle);
         last_cause_q <= last_cause_d;
         rst_cnt_q    <= rst_cnt_d;
         wd_cnt_q     <= wd_cnt_d;
      end
   end

   assign core_reset_o = core_reset_q;
   assign busy_o       = busy_q;
   assign last_cause_o = last_cause_q;
   assign rst_cnt_o    = rst_cnt_q;
   assign wd_cnt_o     = wd_cnt_q;

`ifdef OPENOFDM_RX_RST_CTRL_DROP_CNT_EN
   logic                 drop_evt;
   logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

   // Dropped: watchdog killed by packet completion, anything arriving while busy, or a
   // wd/hdr request losing arbitration in idle.
   assign drop_evt = (wd_rst_req_i & ~req_mask_i[1] & fcs_out_strobe_i)
                   | ((state_q != StIdle) & (wd_e | hdr_e))
                   | ((state_q == StIdle) & ((sw_e & (wd_e | hdr_e)) | (wd_e & hdr_e)));

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_evt) begin
         drop_cnt_d = CNT_WIDTH'(sat_inc(32'(drop_cnt_q), CNT_WIDTH));
      end
      if (cnt_clear_i) begin
         drop_cnt_d = '0;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_openofdm_rx_reset_ctrl.sv
// Bench for openofdm_rx_reset_ctrl: a default instance and a CNT_WIDTH=2 instance share all
// inputs. A timeline model (pulse/holdoff end times) predicts every output each cycle.
module tb_openofdm_rx_reset_ctrl;

   localparam int P  = 16;
   localparam int H  = 64;
   localparam int W  = 16;
   localparam int W2 = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       sw, wd, hdr, fcs, clr;
   logic [2:0] mask;

   logic          core_reset, busy, core_reset2, busy2;
   logic [1:0]    last_cause, last_cause2;
   logic [W-1:0]  rst_cnt, wd_cnt;
   logic [W2-1:0] rst_cnt2, wd_cnt2;
`ifdef OPENOFDM_RX_RST_CTRL_DROP_CNT_EN
   logic [W-1:0]  drop_cnt;
   logic [W2-1:0] drop_cnt2;
`endif

   always #5 clk = ~clk;

   openofdm_rx_reset_ctrl dut (
      .clock_i          (clk),
      .reset_i          (rst),
      .sw_rst_req_i     (sw),
      .wd_rst_req_i     (wd),
      .hdr_err_req_i    (hdr),
      .fcs_out_strobe_i (fcs),
      .req_mask_i       (mask),
      .cnt_clear_i      (clr),
      .core_reset_o     (core_reset),
      .busy_o           (busy),
      .last_cause_o     (last_cause),
      .rst_cnt_o        (rst_cnt),
      .wd_cnt_o         (wd_cnt)
`ifdef OPENOFDM_RX_RST_CTRL_DROP_CNT_EN
      ,
      .drop_cnt_o       (drop_cnt)
`endif
   );

   openofdm_rx_reset_ctrl #(
      .CNT_WIDTH (W2)
   ) dut_w2 (
      .clock_i          (clk),
      .reset_i          (rst),
      .sw_rst_req_i     (sw),
      .wd_rst_req_i     (wd),
      .hdr_err_req_i    (hdr),
      .fcs_out_strobe_i (fcs),
      .req_mask_i       (mask),
      .cnt_clear_i      (clr),
      .core_reset_o     (core_reset2),
      .busy_o           (busy2),
      .last_cause_o     (last_cause2),
      .rst_cnt_o        (rst_cnt2),
      .wd_cnt_o         (wd_cnt2)
`ifdef OPENOFDM_RX_RST_CTRL_DROP_CNT_EN
      ,
      .drop_cnt_o       (drop_cnt2)
`endif
   );

   int errors = 0;
   int checks = 0;

   // Timeline model: k is the current cycle; pulse occupies [ps, pe], busy [ps, he].
   int k, ps, pe, he;
   bit pend, prev_sw;
   int m_cause, m_rst, m_wd, m_drop, m_rst2, m_wd2, m_drop2;
   int hi_cycles, busy_cycles;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v >= mx) ? mx : v + 1;
   endfunction

   task automatic model_reset();
      k = 0; ps = 1; pe = 0; he = 0;
      pend = 1'b0; prev_sw = 1'b0;
      m_cause = 0; m_rst = 0; m_wd = 0; m_drop = 0; m_rst2 = 0; m_wd2 = 0; m_drop2 = 0;
   endtask

   task automatic model_step();
      bit sw_e, wd_e, hdr_e, wd_fcs, busy_now, pulse_now, rise, drop;
      int cause;
      sw_e      = sw && !mask[0];
      wd_e      = wd && !mask[1] && !fcs;
      hdr_e     = hdr && !mask[2];
      wd_fcs    = wd && !mask[1] && fcs;
      busy_now  = (ps <= k) && (k <= he);
      pulse_now = (ps <= k) && (k <= pe);
      rise      = sw_e && !prev_sw;
      cause     = 0;
      if (!busy_now) begin
         if (sw_e) cause = 1;
         else if (wd_e) cause = 2;
         else if (hdr_e) cause = 3;
      end else if (pulse_now) begin
         if (k == pe && sw_e) begin
            pe = k + 1;
            he = k + 1 + H;
         end
      end else begin
         if (rise) pend = 1'b1;
         if (k == he && pend) begin
            cause = 1;
            pend  = 1'b0;
         end
      end
      if (cause != 0) begin
         ps = k + 1; pe = k + P; he = k + P + H;
         m_cause = cause;
         m_rst = sat(m_rst, W); m_rst2 = sat(m_rst2, W2);
         if (cause == 2) begin
            m_wd = sat(m_wd, W); m_wd2 = sat(m_wd2, W2);
         end
      end
      drop = wd_fcs || (busy_now && (wd_e || hdr_e)) ||
             (!busy_now && ((sw_e && (wd_e || hdr_e)) || (wd_e && hdr_e)));
      if (drop) begin
         m_drop = sat(m_drop, W); m_drop2 = sat(m_drop2, W2);
      end
      if (clr) begin
         m_rst = 0; m_wd = 0; m_drop = 0; m_rst2 = 0; m_wd2 = 0; m_drop2 = 0;
      end
      prev_sw = sw_e;
      k++;
   endtask

   task automatic compare_all();
      bit exp_rst, exp_busy;
      exp_rst  = (ps <= k) && (k <= pe);
      exp_busy = (ps <= k) && (k <= he);
      check_eq("core_reset", 32'(core_reset), 32'(exp_rst));
      check_eq("busy", 32'(busy), 32'(exp_busy));
      check_eq("last_cause", 32'(last_cause), 32'(m_cause));
      check_eq("rst_cnt", 32'(rst_cnt), 32'(m_rst));
      check_eq("wd_cnt", 32'(wd_cnt), 32'(m_wd));
      check_eq("core_reset_w2", 32'(core_reset2), 32'(exp_rst));
      check_eq("busy_w2", 32'(busy2), 32'(exp_busy));
      check_eq("last_cause_w2", 32'(last_cause2), 32'(m_cause));
      check_eq("rst_cnt_w2", 32'(rst_cnt2), 32'(m_rst2));
      check_eq("wd_cnt_w2", 32'(wd_cnt2), 32'(m_wd2));
`ifdef OPENOFDM_RX_RST_CTRL_DROP_CNT_EN
      check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      check_eq("drop_cnt_w2", 32'(drop_cnt2), 32'(m_drop2));
`endif
   endtask

   // One clock: DUT and model sample the same inputs, outputs checked on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      if (core_reset) hi_cycles++;
      if (busy) busy_cycles++;
   endtask

   task automatic pulse_wd();
      wd = 1'b1; cycle(); wd = 1'b0;
   endtask

   initial begin
      rst = 1'b1; sw = 1'b0; wd = 1'b0; hdr = 1'b0; fcs = 1'b0; clr = 1'b0; mask = 3'b000;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      compare_all();

      // Watchdog pulse at cycle 10.
      repeat (10) cycle();
      hi_cycles = 0; busy_cycles = 0;
      pulse_wd();
      repeat (100) cycle();
      check_eq("wd_hi_cycles", 32'(hi_cycles), 32'd16);
      check_eq("wd_busy_cycles", 32'(busy_cycles), 32'd80);
      check_eq("wd_cause", 32'(last_cause), 32'd2);
      check_eq("wd_rst_cnt", 32'(rst_cnt), 32'd1);
      check_eq("wd_wd_cnt", 32'(wd_cnt), 32'd1);

      // Software request held for 40 cycles stretches the pulse.
      repeat (5) cycle();
      hi_cycles = 0; busy_cycles = 0;
      sw = 1'b1;
      repeat (40) cycle();
      sw = 1'b0;
      repeat (100) cycle();
      check_eq("sw_hold_hi_cycles", 32'(hi_cycles), 32'd40);
      check_eq("sw_hold_busy_cycles", 32'(busy_cycles), 32'd104);
      check_eq("sw_hold_cause", 32'(last_cause), 32'd1);

      // All three sources in one cycle: a single software-caused pulse.
      hi_cycles = 0;
      sw = 1'b1; wd = 1'b1; hdr = 1'b1;
      cycle();
      sw = 1'b0; wd = 1'b0; hdr = 1'b0;
      repeat (100) cycle();
      check_eq("tri_hi_cycles", 32'(hi_cycles), 32'd16);
      check_eq("tri_cause", 32'(last_cause), 32'd1);
      check_eq("tri_rst_cnt", 32'(rst_cnt), 32'd3);
      check_eq("tri_wd_cnt", 32'(wd_cnt), 32'd1);
`ifdef OPENOFDM_RX_RST_CTRL_DROP_CNT_EN
      check_eq("tri_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

      // hdr ignored in holdoff; sw edge in holdoff queues a pulse right after holdoff.
      clr = 1'b1; cycle(); clr = 1'b0;
      hi_cycles = 0; busy_cycles = 0;
      pulse_wd();
      repeat (29) cycle();
      hdr = 1'b1; cycle(); hdr = 1'b0;
      repeat (5) cycle();
      sw = 1'b1; cycle(); sw = 1'b0;
      repeat (150) cycle();
      check_eq("queued_hi_cycles", 32'(hi_cycles), 32'd32);
      check_eq("queued_busy_cycles", 32'(busy_cycles), 32'd160);
      check_eq("queued_cause", 32'(last_cause), 32'd1);
      check_eq("queued_rst_cnt", 32'(rst_cnt), 32'd2);

      // Watchdog with packet completion, and masked watchdog: no pulse.
      hi_cycles = 0;
      wd = 1'b1; fcs = 1'b1; cycle(); wd = 1'b0; fcs = 1'b0;
      repeat (20) cycle();
      mask = 3'b010;
      pulse_wd();
      repeat (20) cycle();
      mask = 3'b000;
      check_eq("suppressed_hi_cycles", 32'(hi_cycles), 32'd0);
      check_eq("suppressed_rst_cnt", 32'(rst_cnt), 32'd2);

      // Saturation in the 2-bit instance, then clear racing an increment.
      repeat (5) begin
         pulse_wd();
         repeat (99) cycle();
      end
      check_eq("sat_rst_cnt_w2", 32'(rst_cnt2), 32'd3);
      check_eq("sat_wd_cnt_w2", 32'(wd_cnt2), 32'd3);
      check_eq("sat_rst_cnt", 32'(rst_cnt), 32'd7);
      wd = 1'b1; clr = 1'b1; cycle(); wd = 1'b0; clr = 1'b0;
      check_eq("clr_rst_cnt", 32'(rst_cnt), 32'd0);
      check_eq("clr_rst_cnt_w2", 32'(rst_cnt2), 32'd0);
      check_eq("clr_cause", 32'(last_cause), 32'd2);

      // Async reset in the middle of the pulse.
      repeat (4) cycle();
      check_eq("pre_async_core_reset", 32'(core_reset), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("async_core_reset", 32'(core_reset), 32'd0);
      check_eq("async_busy", 32'(busy), 32'd0);
      check_eq("async_core_reset_w2", 32'(core_reset2), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      compare_all();

      // Randomized traffic against the model.
      for (int i = 0; i < 5000; i++) begin
         if (sw) sw = ($urandom_range(0, 7) != 0);
         else    sw = ($urandom_range(0, 79) == 0);
         wd  = ($urandom_range(0, 24) == 0);
         hdr = ($urandom_range(0, 24) == 0);
         fcs = ($urandom_range(0, 5) == 0);
         clr = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 149) == 0) begin
            mask = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
